// File: rtl/axis_stall_pkg.sv
// Shared types for the AXI-Stream stall detector.
// Holds the per-channel state encoding, the kind codes and the cycle classifier.
package axis_stall_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CNT_STARVE = 2'd1,
      CNT_BP     = 2'd2,
      BLOCKED    = 2'd3
   } stall_state_e;

   typedef enum logic [1:0] {
      CLS_NONE   = 2'd0,
      CLS_XFER   = 2'd1,
      CLS_STARVE = 2'd2,
      CLS_BP     = 2'd3
   } cycle_class_e;

   localparam logic [1:0] KIND_NONE   = 2'b00;
   localparam logic [1:0] KIND_STARVE = 2'b01;
   localparam logic [1:0] KIND_BP     = 2'b10;

   // Starvation only counts while the monitored instance claims to be busy.
   function automatic cycle_class_e classify(input logic valid, input logic ready,
                                             input logic instIdle);
      cycle_class_e cls;
      cls = CLS_NONE;
      if (valid && ready) begin
         cls = CLS_XFER;
      end else if (ready && !valid && !instIdle) begin
         cls = CLS_STARVE;
      end else if (valid && !ready) begin
         cls = CLS_BP;
      end
      return cls;
   endfunction

endpackage

// File: rtl/axis_stall_chan.sv
// One monitored stream: classifies each cycle, counts consecutive stalls of
// one kind and reports a registered block flag plus the kind of stall.
module axis_stall_chan
   import axis_stall_pkg::*;
#(
   parameter int STALL_THRESH = 1024,
   parameter int CNT_W        = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable_i,
   input  logic       clear_i,
   input  logic       tvalid_i,
   input  logic       tready_i,
   input  logic       inst_idle_i,
   output logic       block_next_o,
   output logic       block_o,
   output logic [1:0] kind_o
);

   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(STALL_THRESH);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

   stall_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cntInc;
   logic [1:0]       kind_q, kind_d;
   logic             block_q;
   logic [1:0]       kindOut_q;
   cycle_class_e     cls;

   // Next-state logic; the kind register remembers which run is being counted.
   always_comb begin
      cls     = classify(tvalid_i, tready_i, inst_idle_i);
      cntInc  = cnt_q + ONE_C;
      state_d = state_q;
      cnt_d   = cnt_q;
      kind_d  = kind_q;
      if (clear_i || !enable_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         kind_d  = KIND_NONE;
      end else begin
         case (state_q)
            IDLE: begin
               case (cls)
                  CLS_STARVE: begin
                     state_d = CNT_STARVE;
                     cnt_d   = ONE_C;
                     kind_d  = KIND_STARVE;
                  end
                  CLS_BP: begin
                     state_d = CNT_BP;
                     cnt_d   = ONE_C;
                     kind_d  = KIND_BP;
                  end
                  default: begin
                     state_d = IDLE;
                     cnt_d   = '0;
                     kind_d  = KIND_NONE;
                  end
               endcase
            end
            CNT_STARVE: begin
               case (cls)
                  CLS_STARVE: begin
                     cnt_d = cntInc;
                     if (cntInc == THRESH_C) begin
                        state_d = BLOCKED;
                     end
                  end
                  CLS_BP: begin
                     state_d = CNT_BP;
                     cnt_d   = ONE_C;
                     kind_d  = KIND_BP;
                  end
                  default: begin
                     state_d = IDLE;
                     cnt_d   = '0;
                     kind_d  = KIND_NONE;
                  end
               endcase
            end
            CNT_BP: begin
               case (cls)
                  CLS_BP: begin
                     cnt_d = cntInc;
                     if (cntInc == THRESH_C) begin
                        state_d = BLOCKED;
                     end
                  end
                  CLS_STARVE: begin
                     state_d = CNT_STARVE;
                     cnt_d   = ONE_C;
                     kind_d  = KIND_STARVE;
                  end
                  default: begin
                     state_d = IDLE;
                     cnt_d   = '0;
                     kind_d  = KIND_NONE;
                  end
               endcase
            end
            BLOCKED: begin
               // The counter simply holds here, so a long stall never wraps.
               if (cls == CLS_STARVE && kind_q == KIND_STARVE) begin
                  state_d = BLOCKED;
               end else if (cls == CLS_BP && kind_q == KIND_BP) begin
                  state_d = BLOCKED;
               end else if (cls == CLS_STARVE) begin
                  state_d = CNT_STARVE;
                  cnt_d   = ONE_C;
                  kind_d  = KIND_STARVE;
               end else if (cls == CLS_BP) begin
                  state_d = CNT_BP;
                  cnt_d   = ONE_C;
                  kind_d  = KIND_BP;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  kind_d  = KIND_NONE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               kind_d  = KIND_NONE;
            end
         endcase
      end
   end

   // State, counter and outputs all register together so block and kind align.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         kind_q    <= KIND_NONE;
         block_q   <= 1'b0;
         kindOut_q <= KIND_NONE;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         kind_q    <= kind_d;
         block_q   <= (state_d == BLOCKED);
         kindOut_q <= (state_d == BLOCKED) ? kind_d : KIND_NONE;
      end
   end

   assign block_next_o = (state_d == BLOCKED);
   assign block_o      = block_q;
   assign kind_o       = kindOut_q;

endmodule

// File: rtl/axis_stall_detector.sv
// Per-channel AXI-Stream stall detector: one axis_stall_chan per stream plus
// the aggregated any-block flag and a sticky flag for logging.
module axis_stall_detector
   import axis_stall_pkg::*;
#(
   parameter int NUM_CH       = 2,
   parameter int STALL_THRESH = 1024,
   parameter int CNT_W        = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                clear,
   input  logic [NUM_CH-1:0]   tvalid,
   input  logic [NUM_CH-1:0]   tready,
   input  logic                inst_idle,
   output logic [NUM_CH-1:0]   axis_block_sigs,
   output logic [2*NUM_CH-1:0] block_kind,
   output logic                any_block,
   output logic                blocked_sticky
);

   logic [NUM_CH-1:0] blockNext;
   logic              anyBlock_d;
   logic              anyBlock_q;
   logic              sticky_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      axis_stall_chan #(
         .STALL_THRESH(STALL_THRESH),
         .CNT_W       (CNT_W)
      ) u_chan (
         .clock       (clock),
         .reset       (reset),
         .enable_i    (enable),
         .clear_i     (clear),
         .tvalid_i    (tvalid[i]),
         .tready_i    (tready[i]),
         .inst_idle_i (inst_idle),
         .block_next_o(blockNext[i]),
         .block_o     (axis_block_sigs[i]),
         .kind_o      (block_kind[2*i +: 2])
      );
   end

   assign anyBlock_d = |blockNext;

   // Built from the channels' next state so it rises with the per-channel bits.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         anyBlock_q <= 1'b0;
         sticky_q   <= 1'b0;
      end else begin
         anyBlock_q <= anyBlock_d;
         sticky_q   <= sticky_q | anyBlock_d;
      end
   end

   assign any_block      = anyBlock_q;
   assign blocked_sticky = sticky_q;

endmodule
